// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the multi-cycle controller: opcode class view,
// memory function codes, state encoding and datapath select encodings.
package cpu_defs_pkg;

    // One-hot opcode class produced by the classifier.
    typedef struct packed {
        logic r_type;
        logic i_type;
        logic shift;
        logic mem;
        logic cjmp;
        logic jmp;
        logic halt;
    } op_class_t;

    // Memory-class function field (opcode[2:1]); 1x is a no-op.
    localparam logic [1:0] LDM_FN = 2'b00;
    localparam logic [1:0] STM_FN = 2'b01;

    // Controller state encoding.
    typedef logic [3:0] state_t;
    localparam state_t S_FETCH      = 4'd0;
    localparam state_t S_DECODE     = 4'd1;
    localparam state_t S_EXEC_ALU   = 4'd2;
    localparam state_t S_EXEC_SHIFT = 4'd3;
    localparam state_t S_WB_ALU     = 4'd4;
    localparam state_t S_WB_SHIFT   = 4'd5;
    localparam state_t S_MEM_ADDR   = 4'd6;
    localparam state_t S_MEM_RD     = 4'd7;
    localparam state_t S_MEM_WR     = 4'd8;
    localparam state_t S_WB_MEM     = 4'd9;
    localparam state_t S_BRANCH     = 4'd10;
    localparam state_t S_JUMP       = 4'd11;
    localparam state_t S_HALT       = 4'd12;

    // PC source select.
    localparam logic [1:0] PC_SRC_INC = 2'b00;
    localparam logic [1:0] PC_SRC_OFF = 2'b01;
    localparam logic [1:0] PC_SRC_ABS = 2'b10;

    // Register-file write-data select.
    localparam logic [1:0] WDATA_ALU   = 2'b00;
    localparam logic [1:0] WDATA_MEM   = 2'b01;
    localparam logic [1:0] WDATA_SHIFT = 2'b10;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode decoder: 6-bit opcode -> one-hot class plus the
// memory function field.
module opcode_classifier
    import cpu_defs_pkg::*;
(
    input  logic [5:0] i_opcode,
    output op_class_t  o_class,
    output logic [1:0] o_fn
);

    // Bit 0 carries no class or fn information.
    logic w_unused_bit0;
    assign w_unused_bit0 = i_opcode[0];

    assign o_fn = i_opcode[2:1];

    // Priority decode: the first matching prefix wins.
    always_comb begin
        o_class = '0;
        if (i_opcode[5:4] == 2'b00)        o_class.r_type = 1'b1;
        else if (i_opcode[5:4] == 2'b01)   o_class.i_type = 1'b1;
        else if (i_opcode[5:3] == 3'b100)  o_class.shift  = 1'b1;
        else if (i_opcode[5:3] == 3'b101)  o_class.mem    = 1'b1;
        else if (i_opcode[5:3] == 3'b110)  o_class.cjmp   = 1'b1;
        else if (i_opcode[5:2] == 4'b1110) o_class.jmp    = 1'b1;
        else                               o_class.halt   = 1'b1;
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer: registered state machine driving every datapath
// select/enable, with a ready handshake on the shared memory port.
module multicycle_controller
    import cpu_defs_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       cond_true,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic [2:0] alu_op,
    output logic       alu_src_const,
    output logic       rf_write_en,
    output logic [1:0] rf_wdata_sel,
    output logic       reg2_sel_rd,
    output logic       instr_done,
    output logic       halted
);

    state_t     r_state;
    state_t     w_next;
    op_class_t  w_cls;
    logic [1:0] w_fn;
    logic       w_mem_valid;

    opcode_classifier u_classifier (
        .i_opcode (opcode),
        .o_class  (w_cls),
        .o_fn     (w_fn)
    );

    // Only LDM/STM reach the memory states; other memory fns are no-ops.
    assign w_mem_valid = (w_fn == LDM_FN) || (w_fn == STM_FN);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    // Next-state logic; memory states hold until mem_ready.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:      if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                if (w_cls.r_type || w_cls.i_type) w_next = S_EXEC_ALU;
                else if (w_cls.shift)             w_next = S_EXEC_SHIFT;
                else if (w_cls.mem)               w_next = w_mem_valid ? S_MEM_ADDR : S_FETCH;
                else if (w_cls.cjmp)              w_next = S_BRANCH;
                else if (w_cls.jmp)               w_next = S_JUMP;
                else                              w_next = S_HALT;
            end
            S_EXEC_ALU:   w_next = S_WB_ALU;
            S_EXEC_SHIFT: w_next = S_WB_SHIFT;
            S_MEM_ADDR:   w_next = (w_fn == STM_FN) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:     if (mem_ready) w_next = S_WB_MEM;
            S_MEM_WR:     if (mem_ready) w_next = S_FETCH;
            S_WB_ALU, S_WB_SHIFT, S_WB_MEM,
            S_BRANCH, S_JUMP:              w_next = S_FETCH;
            S_HALT:       w_next = S_HALT;
            default:      w_next = S_FETCH;
        endcase
    end

    // Output decode; reset forces everything low so an in-flight request
    // or writeback is dropped in the same cycle.
    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = PC_SRC_INC;
        alu_op        = 3'b000;
        alu_src_const = 1'b0;
        rf_write_en   = 1'b0;
        rf_wdata_sel  = WDATA_ALU;
        reg2_sel_rd   = 1'b0;
        instr_done    = 1'b0;
        halted        = 1'b0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    mem_read = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                S_DECODE:     instr_done = w_cls.mem && !w_mem_valid;
                S_EXEC_ALU: begin
                    alu_op        = opcode[2:0];
                    alu_src_const = w_cls.i_type;
                end
                S_WB_ALU: begin
                    rf_write_en = 1'b1;
                    instr_done  = 1'b1;
                end
                S_WB_SHIFT: begin
                    rf_write_en  = 1'b1;
                    rf_wdata_sel = WDATA_SHIFT;
                    instr_done   = 1'b1;
                end
                S_WB_MEM: begin
                    rf_write_en  = 1'b1;
                    rf_wdata_sel = WDATA_MEM;
                    instr_done   = 1'b1;
                end
                S_MEM_ADDR:   alu_src_const = 1'b1;
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write   = 1'b1;
                    iord        = 1'b1;
                    reg2_sel_rd = 1'b1;
                    instr_done  = mem_ready;
                end
                S_BRANCH: begin
                    pc_src     = PC_SRC_OFF;
                    pc_write   = cond_true;
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    pc_src     = PC_SRC_ABS;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                end
                S_HALT:       halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for multicycle_controller: one vector per
// clock, inputs applied after the rising edge, outputs checked at the
// falling edge against hand-built expected output words.
module tb_multicycle_controller;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [2:0] alu_op;
        logic       alu_src_const;
        logic       rf_write_en;
        logic [1:0] rf_wdata_sel;
        logic       reg2_sel_rd;
        logic       instr_done;
        logic       halted;
    } out_t;

    typedef struct {
        string      name;
        logic       rst;
        logic [5:0] op;
        logic       cond;
        logic       rdy;
        out_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic       cond_true = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_read, mem_write, iord, ir_write, pc_write;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       alu_src_const, rf_write_en;
    logic [1:0] rf_wdata_sel;
    logic       reg2_sel_rd, instr_done, halted;

    int n_vec = 0;
    int n_bad = 0;
    vec_t tbl[$];
    out_t got;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .cond_true     (cond_true),
        .mem_ready     (mem_ready),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .iord          (iord),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .alu_op        (alu_op),
        .alu_src_const (alu_src_const),
        .rf_write_en   (rf_write_en),
        .rf_wdata_sel  (rf_wdata_sel),
        .reg2_sel_rd   (reg2_sel_rd),
        .instr_done    (instr_done),
        .halted        (halted)
    );

    assign got = '{mem_read, mem_write, iord, ir_write, pc_write, pc_src, alu_op,
                   alu_src_const, rf_write_en, rf_wdata_sel, reg2_sel_rd,
                   instr_done, halted};

    // Expected-word builders, one per controller step.
    function automatic out_t e_zero();
        out_t o = '0;
        return o;
    endfunction
    function automatic out_t e_fetch(logic rdy);
        out_t o = '0;
        o.mem_read = 1'b1;
        o.ir_write = rdy;
        o.pc_write = rdy;
        return o;
    endfunction
    function automatic out_t e_exec(logic [2:0] aop, logic imm);
        out_t o = '0;
        o.alu_op = aop;
        o.alu_src_const = imm;
        return o;
    endfunction
    function automatic out_t e_wb(logic [1:0] sel);
        out_t o = '0;
        o.rf_write_en = 1'b1;
        o.rf_wdata_sel = sel;
        o.instr_done = 1'b1;
        return o;
    endfunction
    function automatic out_t e_maddr();
        out_t o = '0;
        o.alu_src_const = 1'b1;
        return o;
    endfunction
    function automatic out_t e_mrd();
        out_t o = '0;
        o.mem_read = 1'b1;
        o.iord = 1'b1;
        return o;
    endfunction
    function automatic out_t e_mwr(logic rdy);
        out_t o = '0;
        o.mem_write = 1'b1;
        o.iord = 1'b1;
        o.reg2_sel_rd = 1'b1;
        o.instr_done = rdy;
        return o;
    endfunction
    function automatic out_t e_branch(logic c);
        out_t o = '0;
        o.pc_src = 2'b01;
        o.pc_write = c;
        o.instr_done = 1'b1;
        return o;
    endfunction
    function automatic out_t e_jump();
        out_t o = '0;
        o.pc_src = 2'b10;
        o.pc_write = 1'b1;
        o.instr_done = 1'b1;
        return o;
    endfunction
    function automatic out_t e_done();
        out_t o = '0;
        o.instr_done = 1'b1;
        return o;
    endfunction
    function automatic out_t e_halt();
        out_t o = '0;
        o.halted = 1'b1;
        return o;
    endfunction

    task automatic add(input string nm, input logic r, input logic [5:0] op,
                       input logic c, input logic rdy, input out_t e);
        vec_t v;
        v.name = nm; v.rst = r; v.op = op; v.cond = c; v.rdy = rdy; v.exp = e;
        tbl.push_back(v);
    endtask

    // One cycle: drive after the rising edge, compare at the falling edge.
    task automatic step(input string nm, input logic r, input logic [5:0] op,
                        input logic c, input logic rdy, input out_t e);
        @(posedge clk);
        #1;
        rst = r; opcode = op; cond_true = c; mem_ready = rdy;
        @(negedge clk);
        n_vec++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL %s: got %05h expected %05h", nm, got, e);
        end
    endtask

    initial begin
        // Reset, then R-type 000010 with zero-wait memory.
        add("rst0",      1, 6'b000000, 0, 1, e_zero());
        add("rst1",      1, 6'b000000, 0, 1, e_zero());
        add("R.fetch",   0, 6'b000010, 0, 1, e_fetch(1));
        add("R.decode",  0, 6'b000010, 0, 1, e_zero());
        add("R.exec",    0, 6'b000010, 0, 1, e_exec(3'b010, 0));
        add("R.wb",      0, 6'b000010, 0, 1, e_wb(2'b00));
        // I-type: immediate B operand.
        add("I.fetch",   0, 6'b010101, 0, 1, e_fetch(1));
        add("I.decode",  0, 6'b010101, 0, 1, e_zero());
        add("I.exec",    0, 6'b010101, 0, 1, e_exec(3'b101, 1));
        add("I.wb",      0, 6'b010101, 0, 1, e_wb(2'b00));
        // Shift.
        add("S.fetch",   0, 6'b100011, 0, 1, e_fetch(1));
        add("S.decode",  0, 6'b100011, 0, 1, e_zero());
        add("S.exec",    0, 6'b100011, 0, 1, e_zero());
        add("S.wb",      0, 6'b100011, 0, 1, e_wb(2'b10));
        // LDM with three wait cycles in MEM_RD: 8 cycles total.
        add("L.fetch",   0, 6'b101000, 0, 1, e_fetch(1));
        add("L.decode",  0, 6'b101000, 0, 1, e_zero());
        add("L.maddr",   0, 6'b101000, 0, 1, e_maddr());
        add("L.rdw0",    0, 6'b101000, 0, 0, e_mrd());
        add("L.rdw1",    0, 6'b101000, 0, 0, e_mrd());
        add("L.rdw2",    0, 6'b101000, 0, 0, e_mrd());
        add("L.rd",      0, 6'b101000, 0, 1, e_mrd());
        add("L.wb",      0, 6'b101000, 0, 1, e_wb(2'b01));
        // STM with a fetch wait and a write wait.
        add("W.fetchw",  0, 6'b101010, 0, 0, e_fetch(0));
        add("W.fetch",   0, 6'b101010, 0, 1, e_fetch(1));
        add("W.decode",  0, 6'b101010, 0, 1, e_zero());
        add("W.maddr",   0, 6'b101010, 0, 1, e_maddr());
        add("W.wrw",     0, 6'b101010, 0, 0, e_mwr(0));
        add("W.wr",      0, 6'b101010, 0, 1, e_mwr(1));
        // Memory fn 1x retires from DECODE.
        add("N.fetch",   0, 6'b101100, 0, 1, e_fetch(1));
        add("N.decode",  0, 6'b101100, 0, 1, e_done());
        // Conditional jump, not taken then taken.
        add("B0.fetch",  0, 6'b110000, 0, 1, e_fetch(1));
        add("B0.decode", 0, 6'b110000, 0, 1, e_zero());
        add("B0.branch", 0, 6'b110000, 0, 1, e_branch(0));
        add("B1.fetch",  0, 6'b110000, 1, 1, e_fetch(1));
        add("B1.decode", 0, 6'b110000, 1, 1, e_zero());
        add("B1.branch", 0, 6'b110000, 1, 1, e_branch(1));
        // Jump, then halt.
        add("J.fetch",   0, 6'b111000, 0, 1, e_fetch(1));
        add("J.decode",  0, 6'b111000, 0, 1, e_zero());
        add("J.jump",    0, 6'b111000, 0, 1, e_jump());
        add("H.fetch",   0, 6'b111100, 0, 1, e_fetch(1));
        add("H.decode",  0, 6'b111100, 0, 1, e_zero());

        foreach (tbl[k])
            step(tbl[k].name, tbl[k].rst, tbl[k].op, tbl[k].cond, tbl[k].rdy, tbl[k].exp);

        // HALT holds for 20 cycles regardless of mem_ready; never retires.
        for (int i = 0; i < 20; i++)
            step("H.hold", 0, 6'b111100, 0, logic'(i[0]), e_halt());
        step("H.rst",     1, 6'b111100, 0, 1, e_zero());
        step("H.refetch", 0, 6'b000001, 0, 0, e_fetch(0));
        step("H.refetch1",0, 6'b000001, 0, 1, e_fetch(1));
        step("H.decode",  0, 6'b000001, 0, 1, e_zero());

        // Reset during an STM write wait drops the request at once.
        step("X.wb",      0, 6'b000001, 0, 1, e_exec(3'b001, 0));
        step("X.wbalu",   0, 6'b000001, 0, 1, e_wb(2'b00));
        step("X.fetch",   0, 6'b101010, 0, 1, e_fetch(1));
        step("X.decode",  0, 6'b101010, 0, 1, e_zero());
        step("X.maddr",   0, 6'b101010, 0, 1, e_maddr());
        step("X.wrw",     0, 6'b101010, 0, 0, e_mwr(0));
        step("X.rst0",    1, 6'b101010, 0, 0, e_zero());
        step("X.rst1",    1, 6'b101010, 0, 1, e_zero());
        step("X.fetchw",  0, 6'b101010, 0, 0, e_fetch(0));
        step("X.fetch",   0, 6'b101010, 0, 1, e_fetch(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
